fp_mult_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier. It replaces the single-cycle FP32 multiplier in the FP datapath. It adds configurable exponent and mantissa widths, round-to-nearest-even, full special-value handling, exception flags, and a valid/ready handshake with backpressure. It sits between the operand issue logic and the FP result writeback, with a 3-stage pipeline and a throughput of one operation per cycle.

---
 rtl/fp_pkg.sv | 42 ++++
 rtl/fp_round_pack.sv | 63 ++++++
 rtl/fp_mult_pipe.sv | 194 +++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// canonical NaN construction for any exponent/mantissa split.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    localparam int unsigned FLAG_W         = 4;
    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    // Widest word the qNaN helper can build; callers truncate to their width.
    localparam int unsigned QNAN_MAX_W = 64;

    // Sign 0, exponent all ones, mantissa MSB set, remaining mantissa bits 0.
    function automatic logic [QNAN_MAX_W-1:0] qnan_pattern(input int unsigned exp_w,
                                                            input int unsigned man_w);
        logic [QNAN_MAX_W-1:0] ones;
        ones = (QNAN_MAX_W'(1) << (exp_w + 1)) - QNAN_MAX_W'(1);
        return ones << (man_w - 1);
    endfunction

    // Subnormals (exp == 0) are flushed and classify as zero.
    function automatic fp_class_e classify(input logic exp_zero,
                                           input logic exp_ones,
                                           input logic man_zero);
        if (exp_zero) begin
            return FP_ZERO;
        end
        if (exp_ones) begin
            return man_zero ? FP_INF : FP_NAN;
        end
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even and pack a raw significand product.
// Purely combinational so arithmetic pipelines can place it in any stage.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [2*MAN_W+1:0]       prod,
    output logic [EXP_W+MAN_W:0]     word_c,
    output logic [FLAG_W-1:0]        flags_c
);

    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned PW      = 2 * MAN_W + 2;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] EXP_TOP  = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    logic                    msb;
    logic [PW-2:0]           norm;
    logic [MAN_W-1:0]        man_t;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic [MAN_W:0]          man_r;
    logic signed [EW-1:0]    exp_n;
    logic signed [EW-1:0]    exp_f;

    // norm holds the bits below the hidden one, aligned so the kept field sits on top.
    always_comb begin
        msb    = prod[PW-1];
        norm   = msb ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        man_t  = norm[PW-2 -: MAN_W];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        inc    = guard & (sticky | man_t[0]);
        man_r  = {1'b0, man_t} + (MAN_W+1)'(inc);
        exp_n  = exp_in + EW'(msb);
        // A rounding carry leaves the mantissa field at zero and bumps the exponent.
        exp_f  = exp_n + EW'(man_r[MAN_W]);
    end

    always_comb begin
        word_c                = {sign, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
        flags_c               = '0;
        flags_c[FLAG_INEXACT] = guard | sticky;
        if (exp_f >= EXP_TOP) begin
            word_c                 = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c[FLAG_OVERFLOW] = 1'b1;
            flags_c[FLAG_INEXACT]  = 1'b1;
        end else if (exp_f <= EXP_ZERO) begin
            word_c                  = {sign, {(W-1){1'b0}}};
            flags_c[FLAG_UNDERFLOW] = 1'b1;
            flags_c[FLAG_INEXACT]   = |prod;
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier (classify, multiply, round/pack)
// with valid/ready flow control and an opaque tag carried per operation.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [FLAG_W-1:0]      flags
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * MAN_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [W-1:0] QNAN = W'(qnan_pattern(EXP_W, MAN_W));

    // Operand decode and special-value resolution (feeds stage 1)
    logic                  sign_a, sign_b;
    logic [EXP_W-1:0]      exp_a, exp_b;
    logic [MAN_W-1:0]      man_a, man_b;
    fp_class_e             cls_a, cls_b;
    logic                  snan_a, snan_b;
    logic                  sign_d;
    logic signed [EW-1:0]  exp_d;
    logic [SW-1:0]         siga_d, sigb_d;
    logic                  spec_d;
    logic [W-1:0]          spec_word_d;
    logic [FLAG_W-1:0]     spec_flags_d;

    // Stage 1 registers
    logic                  v1;
    logic [TAG_W-1:0]      tag1;
    logic                  sign1;
    logic signed [EW-1:0]  exp1;
    logic [SW-1:0]         siga1, sigb1;
    logic                  spec1;
    logic [W-1:0]          spec_word1;
    logic [FLAG_W-1:0]     spec_flags1;

    // Stage 2 registers
    logic                  v2;
    logic [TAG_W-1:0]      tag2;
    logic                  sign2;
    logic signed [EW-1:0]  exp2;
    logic [PW-1:0]         prod2;
    logic                  spec2;
    logic [W-1:0]          spec_word2;
    logic [FLAG_W-1:0]     spec_flags2;

    // Round/pack output and flow control
    logic [W-1:0]          rp_word;
    logic [FLAG_W-1:0]     rp_flags;
    logic                  out_free;
    logic                  ready2;

    always_comb begin
        sign_a = a[W-1];
        exp_a  = a[W-2:MAN_W];
        man_a  = a[MAN_W-1:0];
        sign_b = b[W-1];
        exp_b  = b[W-2:MAN_W];
        man_b  = b[MAN_W-1:0];
        cls_a  = classify(exp_a == '0, &exp_a, man_a == '0);
        cls_b  = classify(exp_b == '0, &exp_b, man_b == '0);
        snan_a = (cls_a == FP_NAN) && !man_a[MAN_W-1];
        snan_b = (cls_b == FP_NAN) && !man_b[MAN_W-1];
        sign_d = sign_a ^ sign_b;
        exp_d  = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);
        siga_d = {cls_a == FP_NORM, man_a};
        sigb_d = {cls_b == FP_NORM, man_b};
    end

    // Special operands bypass the arithmetic result in the last stage.
    always_comb begin
        spec_d       = 1'b1;
        spec_word_d  = '0;
        spec_flags_d = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            spec_word_d                = QNAN;
            spec_flags_d[FLAG_INVALID] = snan_a | snan_b;
        end else if ((cls_a == FP_INF && cls_b == FP_ZERO) ||
                     (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            spec_word_d                = QNAN;
            spec_flags_d[FLAG_INVALID] = 1'b1;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            spec_word_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            spec_word_d = {sign_d, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        out_free = !out_valid || out_ready;
        ready2   = !v2 || out_free;
        in_ready = !v1 || ready2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            tag1        <= '0;
            sign1       <= 1'b0;
            exp1        <= '0;
            siga1       <= '0;
            sigb1       <= '0;
            spec1       <= 1'b0;
            spec_word1  <= '0;
            spec_flags1 <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                tag1        <= in_tag;
                sign1       <= sign_d;
                exp1        <= exp_d;
                siga1       <= siga_d;
                sigb1       <= sigb_d;
                spec1       <= spec_d;
                spec_word1  <= spec_word_d;
                spec_flags1 <= spec_flags_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2          <= 1'b0;
            tag2        <= '0;
            sign2       <= 1'b0;
            exp2        <= '0;
            prod2       <= '0;
            spec2       <= 1'b0;
            spec_word2  <= '0;
            spec_flags2 <= '0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                tag2        <= tag1;
                sign2       <= sign1;
                exp2        <= exp1;
                prod2       <= PW'(siga1) * PW'(sigb1);
                spec2       <= spec1;
                spec_word2  <= spec_word1;
                spec_flags2 <= spec_flags1;
            end
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign    (sign2),
        .exp_in  (exp2),
        .prod    (prod2),
        .word_c  (rp_word),
        .flags_c (rp_flags)
    );

    // Output register holds steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            flags     <= '0;
        end else if (out_free) begin
            out_valid <= v2;
            if (v2) begin
                result  <= spec2 ? spec_word2 : rp_word;
                flags   <= spec2 ? spec_flags2 : rp_flags;
                out_tag <= tag2;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: vector table through a queue scoreboard, plus
// latency, backpressure, mid-flight reset and half-precision sequences.
module tb_fp_mult_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    localparam int NV = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  in_tag, out_tag, flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_in_tag, h_out_tag, h_flags;

    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          out_cnt = 0;
    exp_t        sb[$];
    logic [31:0] exp_res;
    logic [3:0]  exp_flg;
    vec_t        vecs[NV];

    always #5 clk = ~clk;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_tag(out_tag), .flags(flags)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_half (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .in_tag(h_in_tag), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .result(h_result), .out_tag(h_out_tag), .flags(h_flags)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s bound expired", name);
    endtask

    // Present one operation and hold it until the DUT accepts it.
    task automatic send(input vec_t v, input logic [3:0] tag);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        in_tag   = tag;
        exp_res  = v.res;
        exp_flg  = v.flg;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("in_ready_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: log accepted inputs, compare each delivered result in order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (in_valid && in_ready) begin
                e.res = exp_res;
                e.flg = exp_flg;
                e.tag = in_tag;
                sb.push_back(e);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", result, e.res);
                    chk("sb_flags", 32'(flags), 32'(e.flg));
                    chk("sb_tag", 32'(out_tag), 32'(e.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int a0, o0, got_n;
        logic [15:0] hr[2];
        logic [3:0]  hf[2], ht[2];

        // {a, b, tag, result, {invalid, overflow, underflow, inexact}}
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 4'd5,  32'h40400000, 4'b0000};
        vecs[1]  = '{32'hC0000000, 32'h40400000, 4'd1,  32'hC0C00000, 4'b0000};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 4'd2,  32'h3F800002, 4'b0001};
        vecs[3]  = '{32'h7F000000, 32'h40000000, 4'd3,  32'h7F800000, 4'b0101};
        vecs[4]  = '{32'h00800000, 32'h3F000000, 4'd4,  32'h00000000, 4'b0011};
        vecs[5]  = '{32'h7F800000, 32'h00000000, 4'd6,  32'h7FC00000, 4'b1000};
        vecs[6]  = '{32'h7F800001, 32'h3F800000, 4'd7,  32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'h7FC00000, 32'h3F800000, 4'd8,  32'h7FC00000, 4'b0000};
        vecs[8]  = '{32'hFF800000, 32'h40000000, 4'd9,  32'hFF800000, 4'b0000};
        vecs[9]  = '{32'h80000000, 32'h3F800000, 4'd10, 32'h80000000, 4'b0000};
        vecs[10] = '{32'h3F800001, 32'h3FC00000, 4'd11, 32'h3FC00002, 4'b0001};
        vecs[11] = '{32'h3F800003, 32'h3FC00000, 4'd12, 32'h3FC00004, 4'b0001};
        vecs[12] = '{32'h00000000, 32'hFF800000, 4'd13, 32'h7FC00000, 4'b1000};
        vecs[13] = '{32'h00000001, 32'h3F800000, 4'd14, 32'h00000000, 4'b0000};
        vecs[14] = '{32'h7F800000, 32'hFF800000, 4'd15, 32'hFF800000, 4'b0000};
        vecs[15] = '{32'hFFC00000, 32'h7F800001, 4'd0,  32'h7FC00000, 4'b1000};
        vecs[16] = '{32'h3F800000, 32'h3F800000, 4'd3,  32'h3F800000, 4'b0000};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_in_tag = '0; h_out_ready = 1'b1;
        exp_res = '0; exp_flg = '0;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: result appears on the third falling edge after acceptance.
        send(vecs[0], vecs[0].tag);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2", 32'(out_valid), 32'd1 - 32'd1);
        @(negedge clk);
        chk("lat_cycle3", 32'(out_valid), 32'd1);
        drain();

        // Full table back-to-back with the consumer always ready.
        for (int i = 0; i < NV; i++) send(vecs[i], vecs[i].tag);
        in_valid = 1'b0;
        drain();

        // Same table again with a randomly stalling consumer.
        fork
            begin
                for (int i = 0; i < NV; i++) send(vecs[i], vecs[i].tag);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Backpressure: six ops offered while the consumer stalls six cycles.
        a0 = acc_cnt;
        o0 = out_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(vecs[i], 4'(8 + i));
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 6; c++) begin
                    @(negedge clk);
                    if (c >= 4) begin
                        chk("bp_hold_valid", 32'(out_valid), 32'd1);
                        chk("bp_hold_result", result, vecs[0].res);
                        chk("bp_hold_tag", 32'(out_tag), 32'd8);
                    end
                end
                chk("bp_accepts", 32'(acc_cnt - a0), 32'd3);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_outputs", 32'(out_cnt - o0), 32'd6);

        // Asynchronous reset with a full pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(vecs[i], 4'(i + 1));
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        chk("arst_flags", 32'(flags), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        o0 = out_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(vecs[1], 4'hA);
        in_valid = 1'b0;
        drain();
        chk("post_rst_outputs", 32'(out_cnt - o0), 32'd1);

        // Half precision instance.
        h_in_valid = 1'b1; h_a = 16'h3E00; h_b = 16'h4000; h_in_tag = 4'd3;
        @(posedge clk);
        #1;
        h_a = 16'h7800; h_b = 16'h7800; h_in_tag = 4'd4;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        got_n = 0;
        hr[0] = '0; hr[1] = '0; hf[0] = '0; hf[1] = '0; ht[0] = '0; ht[1] = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (h_out_valid && got_n < 2) begin
                hr[got_n] = h_result;
                hf[got_n] = h_flags;
                ht[got_n] = h_out_tag;
                got_n++;
            end
        end
        chk("half_count", 32'(got_n), 32'd2);
        chk("half_mul_res", 32'(hr[0]), 32'h4200);
        chk("half_mul_flags", 32'(hf[0]), 32'h0);
        chk("half_mul_tag", 32'(ht[0]), 32'd3);
        chk("half_ovf_res", 32'(hr[1]), 32'h7C00);
        chk("half_ovf_flags", 32'(hf[1]), 32'b0101);
        chk("half_ovf_tag", 32'(ht[1]), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
